// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: default widths, ALU opcodes and
// the arbiter state encoding.
package alu_pkg;

    localparam int N_DEF  = 16;
    localparam int CW_DEF = 4;

    localparam logic [CW_DEF-1:0] ALU_ADD  = 4'd0;
    localparam logic [CW_DEF-1:0] ALU_AND  = 4'd1;
    localparam logic [CW_DEF-1:0] ALU_OR   = 4'd2;
    localparam logic [CW_DEF-1:0] ALU_XOR  = 4'd3;
    localparam logic [CW_DEF-1:0] ALU_MULT = 4'd4;
    localparam logic [CW_DEF-1:0] ALU_SLL  = 4'd5;
    localparam logic [CW_DEF-1:0] ALU_SLR  = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Searches reqValid starting at
// rrPtr and wrapping at REQS-1 -> 0; returns the first valid requester as a
// one-hot vector and as an index. Kept generic for reuse by other arbiters.
module rr_pick #(
    parameter int REQS  = 4,
    parameter int IDX_W = (REQS > 1) ? $clog2(REQS) : 1
) (
    input  logic [REQS-1:0]  reqValid,
    input  logic [IDX_W-1:0] rrPtr,
    output logic [REQS-1:0]  grantOneHot,
    output logic [IDX_W-1:0] grantIdx,
    output logic             anyValid
);

    logic [IDX_W:0]   sum_s;
    logic [IDX_W:0]   cand_s;
    logic             hit_s;

    // Walk the requesters in rotated order and keep the first valid one
    always_comb begin
        grantOneHot = '0;
        grantIdx    = '0;
        anyValid    = 1'b0;
        sum_s       = '0;
        cand_s      = '0;
        hit_s       = 1'b0;
        for (int k = 0; k < REQS; k++) begin
            sum_s  = {1'b0, rrPtr} + (IDX_W+1)'(k);
            cand_s = (sum_s >= (IDX_W+1)'(REQS)) ? (sum_s - (IDX_W+1)'(REQS)) : sum_s;
            hit_s  = (~anyValid) & reqValid[cand_s[IDX_W-1:0]];
            grantOneHot[cand_s[IDX_W-1:0]] = grantOneHot[cand_s[IDX_W-1:0]] | hit_s;
            grantIdx = hit_s ? cand_s[IDX_W-1:0] : grantIdx;
            anyValid = anyValid | hit_s;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between REQS requesters.
// IDLE picks a requester round-robin and latches its operation, EXEC drives
// the ALU for one cycle and captures its result, RESP returns the result
// over a valid/ready handshake to the owner.
// Optional feature: define ALU_ARB_LOCK_EN to add reqLock, which lets the
// current owner keep the arbiter for back-to-back operations.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int n    = N_DEF,
    parameter int c_w  = CW_DEF,
    parameter int REQS = 4
) (
    input  logic              clk,
    input  logic              rstN,
`ifdef ALU_ARB_LOCK_EN
    input  logic [REQS-1:0]   reqLock,
`endif
    input  logic [REQS-1:0]   reqValid,
    output logic [REQS-1:0]   reqReady,
    input  logic [REQS*c_w-1:0] reqCmd,
    input  logic [REQS*n-1:0] reqSrc1,
    input  logic [REQS*n-1:0] reqSrc2,
    output logic [REQS-1:0]   rspValid,
    input  logic [REQS-1:0]   rspReady,
    output logic [n-1:0]      rspDest,
    output logic              rspZero,
    output logic              rspOverflow,
    output logic [c_w-1:0]    aluCmd,
    output logic [n-1:0]      aluSrc1,
    output logic [n-1:0]      aluSrc2,
    input  logic [n-1:0]      aluDest,
    input  logic              aluZero,
    input  logic              aluOverflow
);

    localparam int IDX_W = (REQS > 1) ? $clog2(REQS) : 1;

    arb_state_t       state_r;
    arb_state_t       state_nxt_s;
    logic [IDX_W-1:0] rr_ptr_r;
    logic [IDX_W-1:0] owner_r;
    logic [c_w-1:0]   cmd_r;
    logic [n-1:0]     src1_r;
    logic [n-1:0]     src2_r;
    logic [n-1:0]     dest_r;
    logic             zero_r;
    logic             ovf_r;

    logic [REQS-1:0]  pick_onehot_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic             pick_any_s;
    logic [REQS-1:0]  win_onehot_s;
    logic [IDX_W-1:0] win_idx_s;
    logic             win_any_s;
    logic [IDX_W-1:0] win_next_ptr_s;
    logic [REQS-1:0]  owner_onehot_s;
    logic             accept_s;
    logic             rsp_done_s;

    rr_pick #(
        .REQS  (REQS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .reqValid    (reqValid),
        .rrPtr       (rr_ptr_r),
        .grantOneHot (pick_onehot_s),
        .grantIdx    (pick_idx_s),
        .anyValid    (pick_any_s)
    );

    assign owner_onehot_s = {{(REQS-1){1'b0}}, 1'b1} << owner_r;

`ifdef ALU_ARB_LOCK_EN
    logic lock_r;
    logic lock_hit_s;

    // A locked owner that is still requesting overrides round-robin order
    always_comb begin
        lock_hit_s = lock_r & reqValid[owner_r];
        if (lock_hit_s) begin
            win_onehot_s = owner_onehot_s;
            win_idx_s    = owner_r;
            win_any_s    = 1'b1;
        end else begin
            win_onehot_s = pick_onehot_s;
            win_idx_s    = pick_idx_s;
            win_any_s    = pick_any_s;
        end
    end

    // Lock is armed by the owner's handshake and consumed or released in IDLE
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            lock_r <= 1'b0;
        end else if (rsp_done_s) begin
            lock_r <= reqLock[owner_r];
        end else if (state_r == IDLE) begin
            lock_r <= 1'b0;
        end else begin
            lock_r <= lock_r;
        end
    end
`else
    assign win_onehot_s = pick_onehot_s;
    assign win_idx_s    = pick_idx_s;
    assign win_any_s    = pick_any_s;
`endif

    assign win_next_ptr_s = (win_idx_s == IDX_W'(REQS-1)) ? {IDX_W{1'b0}} : (win_idx_s + IDX_W'(1));
    assign accept_s       = (state_r == IDLE) && win_any_s;
    assign rsp_done_s     = (state_r == RESP) && rspReady[owner_r];

    // State register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = accept_s ? EXEC : IDLE;
            EXEC:    state_nxt_s = RESP;
            RESP:    state_nxt_s = rsp_done_s ? IDLE : RESP;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from state and owner; nothing granted in reset
    always_comb begin
        reqReady = '0;
        rspValid = '0;
        if ((state_r == IDLE) && rstN) begin
            reqReady = win_onehot_s;
        end else begin
            reqReady = '0;
        end
        if (state_r == RESP) begin
            rspValid = owner_onehot_s;
        end else begin
            rspValid = '0;
        end
    end

    // Operation latch on accept and result capture at the end of EXEC
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rr_ptr_r <= '0;
            owner_r  <= '0;
            cmd_r    <= '0;
            src1_r   <= '0;
            src2_r   <= '0;
            dest_r   <= '0;
            zero_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        owner_r  <= win_idx_s;
                        rr_ptr_r <= win_next_ptr_s;
                        cmd_r    <= reqCmd[win_idx_s*c_w +: c_w];
                        src1_r   <= reqSrc1[win_idx_s*n +: n];
                        src2_r   <= reqSrc2[win_idx_s*n +: n];
                    end
                end
                EXEC: begin
                    dest_r <= aluDest;
                    zero_r <= aluZero;
                    ovf_r  <= aluOverflow;
                end
                default: begin
                    dest_r <= dest_r;
                end
            endcase
        end
    end

    assign aluCmd      = cmd_r;
    assign aluSrc1     = src1_r;
    assign aluSrc2     = src2_r;
    assign rspDest     = dest_r;
    assign rspZero     = zero_r;
    assign rspOverflow = ovf_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter with a behavioural ALU attached to the ALU ports.
// Table-driven single transactions, then hand sequences for fairness,
// backpressure, reset during EXEC and (with ALU_ARB_LOCK_EN) locked bursts.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N  = 16;
    localparam int CW = 4;
    localparam int R  = 4;

    logic            clk = 1'b0;
    logic            rstN;
    logic [R-1:0]    reqValid;
    logic [R-1:0]    reqReady;
    logic [R*CW-1:0] reqCmd;
    logic [R*N-1:0]  reqSrc1;
    logic [R*N-1:0]  reqSrc2;
    logic [R-1:0]    rspValid;
    logic [R-1:0]    rspReady;
    logic [N-1:0]    rspDest;
    logic            rspZero;
    logic            rspOverflow;
    logic [CW-1:0]   aluCmd;
    logic [N-1:0]    aluSrc1;
    logic [N-1:0]    aluSrc2;
    logic [N-1:0]    aluDest;
    logic            aluZero;
    logic            aluOverflow;
`ifdef ALU_ARB_LOCK_EN
    logic [R-1:0]    reqLock;
`endif

    alu_arbiter #(.n(N), .c_w(CW), .REQS(R)) dut (
        .clk         (clk),
        .rstN        (rstN),
`ifdef ALU_ARB_LOCK_EN
        .reqLock     (reqLock),
`endif
        .reqValid    (reqValid),
        .reqReady    (reqReady),
        .reqCmd      (reqCmd),
        .reqSrc1     (reqSrc1),
        .reqSrc2     (reqSrc2),
        .rspValid    (rspValid),
        .rspReady    (rspReady),
        .rspDest     (rspDest),
        .rspZero     (rspZero),
        .rspOverflow (rspOverflow),
        .aluCmd      (aluCmd),
        .aluSrc1     (aluSrc1),
        .aluSrc2     (aluSrc2),
        .aluDest     (aluDest),
        .aluZero     (aluZero),
        .aluOverflow (aluOverflow)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: carry-out of ADD is the overflow flag
    logic [N:0] alu_wide;
    always_comb begin
        alu_wide = 17'd0;
        case (aluCmd)
            ALU_ADD:  alu_wide = {1'b0, aluSrc1} + {1'b0, aluSrc2};
            ALU_AND:  alu_wide = {1'b0, aluSrc1 & aluSrc2};
            ALU_OR:   alu_wide = {1'b0, aluSrc1 | aluSrc2};
            ALU_XOR:  alu_wide = {1'b0, aluSrc1 ^ aluSrc2};
            ALU_MULT: alu_wide = {1'b0, aluSrc1 * aluSrc2};
            ALU_SLL:  alu_wide = {1'b0, aluSrc1 << aluSrc2[3:0]};
            ALU_SLR:  alu_wide = {1'b0, aluSrc1 >> aluSrc2[3:0]};
            default:  alu_wide = 17'd0;
        endcase
    end
    assign aluDest     = alu_wide[N-1:0];
    assign aluOverflow = alu_wide[N];
    assign aluZero     = (alu_wide[N-1:0] == 16'd0);

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [R-1:0] oh(input int i);
        logic [R-1:0] one;
        one = 4'b0001;
        return one << i;
    endfunction

    task automatic set_req(input int i, input logic [CW-1:0] cmd, input logic [N-1:0] a, input logic [N-1:0] b);
        reqCmd[i*CW +: CW] = cmd;
        reqSrc1[i*N +: N]  = a;
        reqSrc2[i*N +: N]  = b;
        reqValid[i]        = 1'b1;
    endtask

    // Advance to the next negedge, then keep going until some reqReady rises (bounded)
    task automatic wait_grant();
        int cyc;
        cyc = 0;
        @(negedge clk); #1;
        while ((reqReady == 4'b0000) && (cyc < 12)) begin
            @(negedge clk); #1;
            cyc++;
        end
    endtask

    typedef struct {
        int         idx;
        logic [3:0] cmd;
        logic [15:0] s1;
        logic [15:0] s2;
        logic [15:0] dest;
        logic       zero;
        logic       ovf;
    } vec_t;

    vec_t vecs[10];
    int   fair_order[5];

    initial begin
        vecs[0] = '{0, 4'd0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0};
        vecs[1] = '{1, 4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
        vecs[2] = '{2, 4'd3, 16'h00F0, 16'h00F0, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{3, 4'd1, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0};
        vecs[4] = '{0, 4'd2, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0};
        vecs[5] = '{1, 4'd4, 16'h0100, 16'h0101, 16'h0100, 1'b0, 1'b0};
        vecs[6] = '{2, 4'd5, 16'h0001, 16'h0004, 16'h0010, 1'b0, 1'b0};
        vecs[7] = '{3, 4'd6, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0};
        vecs[8] = '{0, 4'd15, 16'h1111, 16'h2222, 16'h0000, 1'b1, 1'b0};
        vecs[9] = '{2, 4'd0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
        fair_order = '{0, 1, 2, 3, 0};

        rstN = 1'b0; reqValid = '0; reqCmd = '0; reqSrc1 = '0; reqSrc2 = '0; rspReady = '0;
`ifdef ALU_ARB_LOCK_EN
        reqLock = '0;
`endif
        #1;
        check("rst_reqReady", 32'(reqReady), 32'h0);
        check("rst_rspValid", 32'(rspValid), 32'h0);
        check("rst_rspDest", 32'(rspDest), 32'h0);
        check("rst_flags", 32'({rspZero, rspOverflow}), 32'h0);
        check("rst_alu", 32'({aluCmd, aluSrc1 | aluSrc2}), 32'h0);
        @(negedge clk); @(negedge clk);
        rstN = 1'b1;

        // Table-driven single transactions
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            set_req(vecs[v].idx, vecs[v].cmd, vecs[v].s1, vecs[v].s2);
            #1;
            check($sformatf("v%0d_accept", v), 32'(reqReady), 32'(oh(vecs[v].idx)));
            @(negedge clk);
            reqValid = '0;
            #1;
            check($sformatf("v%0d_exec_cmd", v), 32'(aluCmd), 32'(vecs[v].cmd));
            check($sformatf("v%0d_exec_src", v), {aluSrc1, aluSrc2}, {vecs[v].s1, vecs[v].s2});
            check($sformatf("v%0d_exec_quiet", v), 32'({reqReady, rspValid}), 32'h0);
            @(negedge clk); #1;
            check($sformatf("v%0d_rspValid", v), 32'(rspValid), 32'(oh(vecs[v].idx)));
            check($sformatf("v%0d_rspDest", v), 32'(rspDest), 32'(vecs[v].dest));
            check($sformatf("v%0d_flags", v), 32'({rspZero, rspOverflow}), 32'({vecs[v].zero, vecs[v].ovf}));
            rspReady = oh(vecs[v].idx);
            @(negedge clk);
            rspReady = '0;
            #1;
            check($sformatf("v%0d_rsp_done", v), 32'(rspValid), 32'h0);
        end

        // Fairness: all requesters valid continuously from reset
        @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        for (int i = 0; i < R; i++) set_req(i, ALU_ADD, 16'(i), 16'h0100);
        rspReady = 4'b1111;
        rstN = 1'b1;
        #1;
        check("fair_grant0", 32'(reqReady), 32'(oh(fair_order[0])));
        for (int g = 0; g < 5; g++) begin
            if (g > 0) begin
                wait_grant();
                check($sformatf("fair_grant%0d", g), 32'(reqReady), 32'(oh(fair_order[g])));
            end
            @(negedge clk); #1;
            check($sformatf("fair_pulse%0d", g), 32'(reqReady), 32'h0);
            @(negedge clk); #1;
            check($sformatf("fair_rsp%0d", g), 32'(rspValid), 32'(oh(fair_order[g])));
            check($sformatf("fair_dest%0d", g), 32'(rspDest), 32'h0100 + 32'(fair_order[g]));
            check($sformatf("fair_busy%0d", g), 32'(reqReady), 32'h0);
        end
        reqValid = '0;
        @(negedge clk);
        rspReady = '0;

        // Backpressure on requester 2 with requester 0 also waiting (rrPtr=1)
        set_req(2, ALU_SLL, 16'h0003, 16'h0002);
        set_req(0, ALU_OR, 16'h5A00, 16'h00A5);
        #1;
        check("bp_accept", 32'(reqReady), 32'(oh(2)));
        @(negedge clk);
        reqValid[2] = 1'b0;
        @(negedge clk);
        rspReady = 4'b1011;
        for (int w = 0; w < 5; w++) begin
            #1;
            check($sformatf("bp_hold_valid%0d", w), 32'(rspValid), 32'(oh(2)));
            check($sformatf("bp_hold_dest%0d", w), 32'(rspDest), 32'h000C);
            check($sformatf("bp_hold_cmd%0d", w), 32'(aluCmd), 32'(ALU_SLL));
            check($sformatf("bp_no_ready%0d", w), 32'(reqReady), 32'h0);
            @(negedge clk);
        end
        rspReady = oh(2);
        @(negedge clk);
        rspReady = '0;
        #1;
        check("bp_idle_grant", 32'(reqReady), 32'(oh(0)));
        check("bp_rsp_clear", 32'(rspValid), 32'h0);
        @(negedge clk);
        reqValid[0] = 1'b0;
        @(negedge clk); #1;
        check("bp_req0_dest", 32'(rspDest), 32'h5AA5);
        rspReady = oh(0);
        @(negedge clk);
        rspReady = '0;

        // Reset while requester 3 is in EXEC (rrPtr=1 here)
        set_req(3, ALU_XOR, 16'h1234, 16'h00FF);
        #1;
        check("rm_accept", 32'(reqReady), 32'(oh(3)));
        @(negedge clk);
        reqValid = '0;
        #1;
        check("rm_exec_cmd", 32'(aluCmd), 32'(ALU_XOR));
        rstN = 1'b0;
        #1;
        check("rm_alu_zero", 32'({aluCmd, aluSrc1 | aluSrc2}), 32'h0);
        check("rm_rsp_zero", 32'({rspValid, rspZero, rspOverflow}), 32'h0);
        check("rm_dest_zero", 32'(rspDest), 32'h0);
        set_req(1, ALU_ADD, 16'h1000, 16'h0234);
        set_req(3, ALU_AND, 16'hFF00, 16'h0FF0);
        #1;
        check("rm_no_ready_in_reset", 32'(reqReady), 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        #1;
        check("rm_first_grant", 32'(reqReady), 32'(oh(1)));
        check("rm_no_stale_rsp", 32'(rspValid), 32'h0);
        @(negedge clk);
        reqValid[1] = 1'b0;
        @(negedge clk); #1;
        check("rm_req1_rsp", 32'({rspValid, rspDest}), {16'(oh(1)), 16'h1234});
        rspReady = oh(1);
        @(negedge clk);
        rspReady = '0;
        #1;
        check("rm_second_grant", 32'(reqReady), 32'(oh(3)));
        @(negedge clk);
        reqValid[3] = 1'b0;
        @(negedge clk); #1;
        check("rm_req3_rsp", 32'({rspValid, rspDest}), {16'(oh(3)), 16'h0F00});
        rspReady = oh(3);
        @(negedge clk);
        rspReady = '0;

`ifdef ALU_ARB_LOCK_EN
        // Locked burst: requester 2 keeps the ALU for three SLL ops (rrPtr=0)
        set_req(2, ALU_SLL, 16'h0003, 16'h0001);
        reqLock[2] = 1'b1;
        #1;
        check("lk_grant0", 32'(reqReady), 32'(oh(2)));
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                wait_grant();
                check($sformatf("lk_grant%0d", k), 32'(reqReady), 32'(oh(2)));
            end
            @(negedge clk);
            set_req(0, ALU_ADD, 16'h0040, 16'h0002);
            if (k < 2) set_req(2, ALU_SLL, 16'h0003, 16'(k + 2));
            else reqValid[2] = 1'b0;
            @(negedge clk); #1;
            check($sformatf("lk_rsp%0d", k), 32'({rspValid, rspDest}), {16'(oh(2)), 16'h0003 << (k + 1)});
            if (k == 2) reqLock[2] = 1'b0;
            rspReady = oh(2);
        end
        wait_grant();
        rspReady = '0;
        check("lk_release_grant", 32'(reqReady), 32'(oh(0)));
        @(negedge clk);
        reqValid[0] = 1'b0;
        @(negedge clk); #1;
        check("lk_req0_rsp", 32'({rspValid, rspDest}), {16'(oh(0)), 16'h0042});
        rspReady = oh(0);
        @(negedge clk);
        rspReady = '0;
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
